// File: rtl/wlo_cmd_master.sv
// Command master for the WLO serial link: sends the configuration frame and start command,
// then collects the 16-byte result, with a soft-reset command path and an rx inactivity timeout.
module wlo_cmd_master #(
   parameter int NUM_CHAN = 15,
   parameter int TIMEOUT  = 1000000
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      cmd_go,
   input  logic                      cmd_rst,
   input  logic [8*2*NUM_CHAN-1:0]   frac_cfg,
   output logic                      tx_valid,
   output logic [7:0]                tx_data,
   input  logic                      tx_ready,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_data,
   output logic [127:0]              mse_out,
   output logic                      mse_valid,
   output logic                      busy,
   output logic                      timeout
);

   localparam int NB = 2 * NUM_CHAN;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [7:0] BYTE_START = 8'h01;
   localparam logic [7:0] BYTE_HDR   = 8'h02;
   localparam logic [7:0] BYTE_RST   = 8'h04;

   typedef enum logic [2:0] {
      IDLE,
      SEND_HDR,
      SEND_CFG,
      SEND_START,
      WAIT_RX,
      DONE,
      SEND_RST
   } state_t;

   state_t            state_q, state_d;
   logic [8*NB-1:0]   cfg_q, cfg_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [3:0]        rx_cnt_q, rx_cnt_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [127:0]      rx_buf_q, rx_buf_d;
   logic [127:0]      mse_q, mse_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              mse_valid_q, mse_valid_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic              xfer;

   assign xfer = tx_valid_q && tx_ready;

   always_comb begin
      state_d     = state_q;
      cfg_d       = cfg_q;
      idx_d       = idx_q;
      rx_cnt_d    = rx_cnt_q;
      tmo_d       = tmo_q;
      rx_buf_d    = rx_buf_q;
      mse_d       = mse_q;
      mse_valid_d = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            // Soft reset has priority; a simultaneous go is dropped, not deferred.
            if (cmd_rst) begin
               state_d = SEND_RST;
            end else if (cmd_go) begin
               state_d = SEND_HDR;
               cfg_d   = frac_cfg;
            end
         end
         SEND_HDR: begin
            if (xfer) begin
               state_d = SEND_CFG;
               idx_d   = '0;
            end
         end
         SEND_CFG: begin
            if (xfer) begin
               if (idx_q == IDX_LAST) begin
                  state_d = SEND_START;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         SEND_START: begin
            if (xfer) begin
               state_d  = WAIT_RX;
               rx_cnt_d = '0;
               tmo_d    = '0;
            end
         end
         WAIT_RX: begin
            // Bytes land in a shadow buffer so an aborted collection leaves mse_out intact.
            if (rx_valid) begin
               rx_buf_d[{rx_cnt_q, 3'b000} +: 8] = rx_data;
               rx_cnt_d = rx_cnt_q + 1'b1;
               tmo_d    = '0;
               if (rx_cnt_q == 4'd15) begin
                  state_d     = DONE;
                  mse_d       = rx_buf_d;
                  mse_valid_d = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         SEND_RST: begin
            if (xfer) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      case (state_d)
         SEND_HDR: begin
            tx_valid_d = 1'b1;
            tx_data_d  = BYTE_HDR;
         end
         SEND_CFG: begin
            tx_valid_d = 1'b1;
            tx_data_d  = cfg_d[{idx_d, 3'b000} +: 8];
         end
         SEND_START: begin
            tx_valid_d = 1'b1;
            tx_data_d  = BYTE_START;
         end
         SEND_RST: begin
            tx_valid_d = 1'b1;
            tx_data_d  = BYTE_RST;
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cfg_q       <= '0;
         idx_q       <= '0;
         rx_cnt_q    <= '0;
         tmo_q       <= '0;
         rx_buf_q    <= '0;
         mse_q       <= '0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         mse_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cfg_q       <= cfg_d;
         idx_q       <= idx_d;
         rx_cnt_q    <= rx_cnt_d;
         tmo_q       <= tmo_d;
         rx_buf_q    <= rx_buf_d;
         mse_q       <= mse_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         mse_valid_q <= mse_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign mse_out   = mse_q;
   assign mse_valid = mse_valid_q;
   assign busy      = busy_q;
   assign timeout   = timeout_q;

endmodule

// File: doc/wlo_cmd_master.md
WLO_CMD_MASTER -- requirements
Module: wlo_cmd_master

Interface
REQ-001 The block SHALL have parameter NUM_CHAN, default 15, meaning the number of channels per bank; 2*NUM_CHAN fraction bytes are sent per configuration.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000000, meaning the maximum number of clk cycles allowed between received result bytes.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port cmd_go, input, 1, a one-cycle pulse that requests the full sequence: configure, start, collect.
REQ-006 The block SHALL have port cmd_rst, input, 1, a one-cycle pulse that requests a soft-reset command only.
REQ-007 The block SHALL have port frac_cfg, input, 8*2*NUM_CHAN, the fraction switch bytes; byte n is frac_cfg[8n+7:8n].
REQ-008 The block SHALL have port tx_valid, output, 1, meaning a byte is offered to the serial transmitter.
REQ-009 The block SHALL have port tx_data, output, 8, the offered byte.
REQ-010 The block SHALL have port tx_ready, input, 1, meaning the transmitter accepts the byte this cycle.
REQ-011 The block SHALL have port rx_valid, input, 1, a one-cycle strobe for each byte received from the serial receiver.
REQ-012 The block SHALL have port rx_data, input, 8, the received byte.
REQ-013 The block SHALL have port mse_out, output, 128, the assembled result: [63:0] is bank 0 and [127:64] is bank 1.
REQ-014 The block SHALL have port mse_valid, output, 1, a one-cycle pulse meaning mse_out has been updated.
REQ-015 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 The block SHALL have port timeout, output, 1, a one-cycle pulse meaning result collection was aborted.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, SEND_HDR, SEND_CFG, SEND_START, WAIT_RX, DONE and SEND_RST.
REQ-018 A byte SHALL be transferred only in a cycle where tx_valid && tx_ready; tx_data SHALL remain stable while tx_valid && !tx_ready.
REQ-019 In IDLE, a cmd_go pulse SHALL latch frac_cfg into an internal register and move to SEND_HDR, so tx_valid=1 with tx_data=0x02 in the next cycle.
REQ-020 SEND_HDR SHALL move to SEND_CFG when its byte transfers.
REQ-021 SEND_CFG SHALL offer latched bytes 0 to 2*NUM_CHAN-1 in ascending order, using a byte index that advances only on transfer.
REQ-022 SEND_CFG SHALL move to SEND_START after byte 2*NUM_CHAN-1 transfers.
REQ-023 SEND_START SHALL offer 0x01 and, when it transfers, clear the rx byte counter and the timeout counter, then move to WAIT_RX.
REQ-024 In WAIT_RX, each rx_valid SHALL store byte k (k=0..15) into mse_out[8k+7:8k] (little-endian) and increment k.
REQ-025 In WAIT_RX, the timeout counter SHALL clear on every rx_valid and otherwise increment.
REQ-026 WAIT_RX SHALL move to DONE on the cycle in which byte 15 is stored.
REQ-027 DONE SHALL assert mse_valid for exactly one cycle (one cycle after byte 15 arrives) and then return to IDLE.
REQ-028 If the timeout counter reaches TIMEOUT-1 without rx_valid, the block SHALL pulse timeout, return to IDLE, leave mse_out at its previous value, and not assert mse_valid.
REQ-029 In IDLE, a cmd_rst pulse SHALL move to SEND_RST, which offers 0x04 and returns to IDLE on transfer.
REQ-030 If cmd_go and cmd_rst are both high in IDLE, cmd_rst SHALL win and cmd_go SHALL be dropped.
REQ-031 cmd_go and cmd_rst SHALL be ignored while busy=1; they SHALL not be queued.
REQ-032 rx_valid outside WAIT_RX SHALL be discarded with no state change.
REQ-033 rx_valid in the same cycle as the SEND_START transfer SHALL be discarded.
REQ-034 tx_valid SHALL be 1 only in SEND_HDR, SEND_CFG, SEND_START and SEND_RST.
REQ-035 tx_valid SHALL drop in the cycle after the final byte of a state transfers, unless the next state also sends.
REQ-036 A later frac_cfg change during a sequence SHALL not affect the bytes sent.

Reset
REQ-037 While rstn=0, regardless of clk, the block SHALL hold state=IDLE, tx_valid=0, tx_data=0x00, mse_out=0, mse_valid=0, busy=0 and timeout=0, with all counters and the latched configuration at 0.
REQ-038 An rstn assertion mid-sequence SHALL abort that sequence immediately, with no further bytes offered.
REQ-039 After rstn deasserts, the block SHALL respond to cmd_go in the first cycle that follows a rising clk edge.

Verification
REQ-040 Bench SHALL cover: NUM_CHAN=15, frac_cfg byte n = n+0x10, tx_ready tied 1, cmd_go -> tx stream 0x02, 0x10..0x2D (30 bytes), 0x01 on 32 consecutive cycles, then busy stays 1.
REQ-041 Bench SHALL cover: after the start byte, 16 rx bytes 0x00..0x0F with random gaps -> mse_out[63:0]=0x0706050403020100, mse_out[127:64]=0x0F0E0D0C0B0A0908, one mse_valid pulse one cycle after the last byte, then busy=0.
REQ-042 Bench SHALL cover: tx_ready toggling 1,0,0,1 -> tx_data holds during stall, no bytes lost or duplicated, 32 bytes total.
REQ-043 Bench SHALL cover: TIMEOUT=100, only 5 rx bytes -> timeout pulse 100 cycles after the 5th byte, mse_valid never 1, mse_out unchanged.
REQ-044 Bench SHALL cover: cmd_go and cmd_rst together in IDLE -> single byte 0x04 then IDLE; cmd_go during WAIT_RX -> ignored.
REQ-045 Bench SHALL cover: rstn asserted asynchronously mid-SEND_CFG -> tx_valid=0 and busy=0 without a clk edge; a fresh cmd_go restarts at 0x02.
